// File: rtl/uart_tx_engine.sv
// UART transmit serialiser: start, LSB-first data, optional parity (UART_TX_PARITY_EN), stop.
// Latency: start bit on tx the cycle after load; tx_done pulses one cycle after the stop bit; load is ignored while busy.
module uart_tx_engine #(
    parameter int DIV_W = 19
) (
    input  logic             clk,
    input  logic             rst_s,
    input  logic [DIV_W-1:0] baud_k,
    input  logic             load,
    input  logic [7:0]       data_in,
    input  logic             eight,
    input  logic             pen,
    input  logic             ohel,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
        PAR   = 3'd3,
`endif
        STOP  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] k_q, k_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             eight_q, eight_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIV_W-1:0] k_clamped;
    logic [2:0]       last_bit;
    logic [2:0]       bit_nxt;
    logic             bit_tick;

`ifdef UART_TX_PARITY_EN
    logic pen_q, pen_d;
    logic ohel_q, ohel_d;
    logic par_bit;
    // Bit 7 is excluded from parity in 7-bit mode even though it was latched.
    assign par_bit = (^(data_q & {eight_q, 7'h7F})) ^ ohel_q;
`else
    logic unused_cfg;
    assign unused_cfg = pen ^ ohel;
`endif

    assign k_clamped = (baud_k < DIV_W'(2)) ? DIV_W'(2) : baud_k;
    assign last_bit  = eight_q ? 3'd7 : 3'd6;
    assign bit_nxt   = bit_q + 3'd1;
    assign bit_tick  = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        bit_d   = bit_q;
        data_d  = data_q;
        eight_d = eight_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        pen_d   = pen_q;
        ohel_d  = ohel_q;
`endif

        if (state_q != IDLE && !bit_tick) begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (load) begin
                    data_d  = data_in;
                    k_d     = k_clamped;
                    eight_d = eight;
`ifdef UART_TX_PARITY_EN
                    pen_d   = pen;
                    ohel_d  = ohel;
`endif
                    cnt_d   = k_clamped - DIV_W'(1);
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    cnt_d   = k_q - DIV_W'(1);
                    bit_d   = 3'd0;
                    tx_d    = data_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    cnt_d = k_q - DIV_W'(1);
                    if (bit_q == last_bit) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
`ifdef UART_TX_PARITY_EN
                        if (pen_q) begin
                            tx_d    = par_bit;
                            state_d = PAR;
                        end
`endif
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = data_q[bit_nxt];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PAR: begin
                if (bit_tick) begin
                    cnt_d   = k_q - DIV_W'(1);
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            bit_q   <= 3'd0;
            data_q  <= 8'h00;
            eight_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            pen_q   <= 1'b0;
            ohel_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            eight_q <= eight_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            pen_q   <= pen_d;
            ohel_q  <= ohel_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frame shapes, timing, back-to-back, reset and divisor clamping.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        rst_s;
    logic [18:0] baud_k;
    logic        load;
    logic [7:0]  data_in;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic        tx;
    logic        busy;
    logic        tx_done;

    int checks = 0;
    int errors = 0;

    uart_tx_engine #(.DIV_W(19)) dut (
        .clk     (clk),
        .rst_s   (rst_s),
        .baud_k  (baud_k),
        .load    (load),
        .data_in (data_in),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the first start-bit cycle.
    task automatic start_load(input logic [7:0] d, input logic [18:0] k,
                              input logic e, input logic p, input logic o);
        data_in = d;
        baud_k  = k;
        eight   = e;
        pen     = p;
        ohel    = o;
        load    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load    = 1'b0;
    endtask

    // bits[0] is the start bit; ends at the falling edge of the tx_done cycle.
    // At cycle 'glitch' a stray load plus config changes are driven.
    task automatic expect_frame(input string tag, input logic [11:0] bits,
                                input int nbits, input int k, input int glitch);
        for (int c = 0; c < nbits * k; c++) begin
            chk({tag, "_tx"},   {11'd0, tx},      {11'd0, bits[c / k]});
            chk({tag, "_busy"}, {11'd0, busy},    12'd1);
            chk({tag, "_done"}, {11'd0, tx_done}, 12'd0);
            if (c == glitch) begin
                load    = 1'b1;
                data_in = ~data_in;
                baud_k  = baud_k + 19'd5;
                eight   = ~eight;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        chk({tag, "_done_pulse"}, {11'd0, tx_done}, 12'd1);
        chk({tag, "_busy_end"},   {11'd0, busy},    12'd0);
        chk({tag, "_tx_end"},     {11'd0, tx},      12'd1);
    endtask

    initial begin
        rst_s   = 1'b1;
        load    = 1'b0;
        data_in = 8'h00;
        baud_k  = 19'd4;
        eight   = 1'b1;
        pen     = 1'b0;
        ohel    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx",   {11'd0, tx},      12'd1);
        chk("rst_busy", {11'd0, busy},    12'd0);
        chk("rst_done", {11'd0, tx_done}, 12'd0);
        rst_s = 1'b0;
        @(negedge clk);
        chk("idle_tx", {11'd0, tx}, 12'd1);

        // 0x55, k=4: alternating 0/1 from the start bit, tx_done at N+41
        start_load(8'h55, 19'd4, 1'b1, 1'b0, 1'b0);
        expect_frame("t1", 12'b0010_1010_1010, 10, 4, -1);
        @(negedge clk);
        chk("t1_single_pulse", {11'd0, tx_done}, 12'd0);
        chk("t1_idle_tx",      {11'd0, tx},      12'd1);

        // 7-bit 0xFF, k=2: seven ones, bit 7 never sent
        start_load(8'hFF, 19'd2, 1'b0, 1'b0, 1'b0);
        expect_frame("t3", 12'b0001_1111_1110, 9, 2, -1);
        @(negedge clk);

`ifdef UART_TX_PARITY_EN
        // 0x07 has odd weight: even parity bit 1, odd parity bit 0
        start_load(8'h07, 19'd3, 1'b1, 1'b1, 1'b0);
        expect_frame("t2_even", 12'b0110_0000_1110, 11, 3, -1);
        @(negedge clk);
        start_load(8'h07, 19'd3, 1'b1, 1'b1, 1'b1);
        expect_frame("t2_odd", 12'b0100_0000_1110, 11, 3, -1);
        @(negedge clk);
`else
        // pen is ignored in this build: plain 10-bit frame
        start_load(8'h07, 19'd3, 1'b1, 1'b1, 1'b0);
        expect_frame("t2_nopar", 12'b0010_0000_1110, 10, 3, -1);
        @(negedge clk);
`endif

        // Back-to-back with stray mid-frame loads
        start_load(8'hA5, 19'd3, 1'b1, 1'b0, 1'b0);
        expect_frame("t4a", 12'b0011_0100_1010, 10, 3, 7);
        start_load(8'h3C, 19'd3, 1'b1, 1'b0, 1'b0);
        expect_frame("t4b", 12'b0010_0111_1000, 10, 3, 20);
        @(negedge clk);

        // Reset during the data phase abandons the frame silently
        start_load(8'hC3, 19'd2, 1'b1, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        chk("t5_busy_mid", {11'd0, busy}, 12'd1);
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0;
        chk("t5_rst_tx",   {11'd0, tx},      12'd1);
        chk("t5_rst_busy", {11'd0, busy},    12'd0);
        chk("t5_rst_done", {11'd0, tx_done}, 12'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("t5_quiet_done", {11'd0, tx_done}, 12'd0);
            chk("t5_quiet_tx",   {11'd0, tx},      12'd1);
        end
        start_load(8'h01, 19'd2, 1'b1, 1'b0, 1'b0);
        expect_frame("t5_clean", 12'b0010_0000_0010, 10, 2, -1);
        @(negedge clk);

        // Divisors 0 and 1 clamp to 2; mid-frame divisor changes have no effect
        start_load(8'h96, 19'd0, 1'b1, 1'b0, 1'b0);
        expect_frame("t6_k0", 12'b0011_0010_1100, 10, 2, 5);
        @(negedge clk);
        start_load(8'h2A, 19'd1, 1'b0, 1'b0, 1'b0);
        expect_frame("t6_k1", 12'b0001_0101_0100, 9, 2, 3);
        @(negedge clk);
        chk("end_idle_tx",   {11'd0, tx},   12'd1);
        chk("end_idle_busy", {11'd0, busy}, 12'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
